// File: rtl/if_buffer_mp.sv
// Multi-port instruction fetch buffer: circular queue, up to ENQ_W writes and DEQ_W show-ahead reads per cycle.
// Optional macro IF_BUFFER_MP_BYPASS_EN: an empty buffer forwards accepted enqueue lanes to the deq outputs in the same cycle.
module if_buffer_mp #(
    parameter int DEPTH   = 16,
    parameter int INSTR_W = 32,
    parameter int ENQ_W   = 4,
    parameter int DEQ_W   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         enq_valid,
    input  logic [$clog2(ENQ_W+1)-1:0]   enq_cnt,
    input  logic [ENQ_W*INSTR_W-1:0]     enq_data,
    input  logic [63:0]                  enq_pc,
    output logic                         enq_ready,
    output logic [$clog2(DEQ_W+1)-1:0]   deq_avail,
    output logic [DEQ_W*INSTR_W-1:0]     deq_data,
    output logic [DEQ_W*64-1:0]          deq_pc,
    input  logic [$clog2(DEQ_W+1)-1:0]   deq_take,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ENQ_CW = $clog2(ENQ_W + 1);
    localparam int DEQ_CW = $clog2(DEQ_W + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [63:0]        r_pc  [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_ready;
    logic               w_enq_fire;
    logic               w_byp;
    logic [ENQ_CW-1:0]  w_enq_n;
    logic [DEQ_CW-1:0]  w_avail;
    logic [DEQ_CW-1:0]  w_take;
    logic [DEQ_CW-1:0]  w_skip;
    logic [ENQ_W-1:0]   w_wen;
    logic [PTR_W-1:0]   w_waddr [ENQ_W];

    // Readiness looks only at the registered count; a same-cycle dequeue earns no credit.
    assign w_ready    = (r_count <= CNT_W'(DEPTH - ENQ_W));
    assign w_enq_fire = enq_valid && w_ready && !flush_i &&
                        (enq_cnt != '0) && (32'(enq_cnt) <= ENQ_W);
    assign w_enq_n    = w_enq_fire ? enq_cnt : '0;

`ifdef IF_BUFFER_MP_BYPASS_EN
    assign w_byp = w_enq_fire && (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        if (w_byp)
            w_avail = (32'(enq_cnt) >= DEQ_W) ? DEQ_CW'(DEQ_W) : DEQ_CW'(enq_cnt);
        else
            w_avail = (32'(r_count) >= DEQ_W) ? DEQ_CW'(DEQ_W) : DEQ_CW'(r_count);
        w_take = (deq_take > w_avail) ? w_avail : deq_take;
        // Bypassed lanes consumed this cycle are never written into storage.
        w_skip = w_byp ? w_take : '0;
    end

    always_comb begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            w_wen[i]   = w_enq_fire && (32'(enq_cnt) > i) && (i >= 32'(w_skip));
            w_waddr[i] = r_tail + PTR_W'(i) - PTR_W'(w_skip);
        end
    end

    always_comb begin
        deq_data = '0;
        deq_pc   = '0;
        for (int unsigned i = 0; i < DEQ_W; i++) begin
            if (rst_n && (i < 32'(w_avail))) begin
                if (w_byp) begin
                    deq_data[i*INSTR_W +: INSTR_W] = enq_data[(i % ENQ_W)*INSTR_W +: INSTR_W];
                    deq_pc[i*64 +: 64]             = enq_pc + (64'(i) << 2);
                end else begin
                    deq_data[i*INSTR_W +: INSTR_W] = r_mem[r_head + PTR_W'(i)];
                    deq_pc[i*64 +: 64]             = r_pc[r_head + PTR_W'(i)];
                end
            end
        end
    end

    assign deq_avail = rst_n ? w_avail : '0;
    assign enq_ready = !rst_n || w_ready;
    assign occupancy = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_take - w_skip);
            r_tail  <= r_tail + PTR_W'(w_enq_n) - PTR_W'(w_skip);
            r_count <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_take);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < ENQ_W; i++) begin
            if (w_wen[i]) begin
                r_mem[w_waddr[i]] <= enq_data[i*INSTR_W +: INSTR_W];
                r_pc[w_waddr[i]]  <= enq_pc + (64'(i) << 2);
            end
        end
    end

endmodule
